// File: rtl/execute_ctrl_pkg.sv
// execute_ctrl_pkg: shared FSM encoding, counter width and saturating increment for execute_ctrl.
package execute_ctrl_pkg;
   localparam int CNT_W = 32;
   typedef enum logic [1:0] {EMPTY = 2'd0, FULL = 2'd1, HOLD = 2'd2} state_t;
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return &v ? v : v + 1'b1;
   endfunction
endpackage

// File: rtl/execute_ctrl_if.sv
// execute_ctrl_if: decode/execute handshake, hazard operands, flush and perf counters.
interface execute_ctrl_if;
   import execute_ctrl_pkg::*;
   logic             dec_valid_i;
   logic             dec_ready_o;
   logic [4:0]       dec_rs1_i;
   logic [4:0]       dec_rs2_i;
   logic             dec_rs1_used_i;
   logic             dec_rs2_used_i;
   logic             dec_is_load_i;
   logic             dec_wena_i;
   logic [4:0]       dec_waddr_i;
   logic             ex_valid_o;
   logic             ex_ready_i;
   logic             flush_i;
   logic             we_o;
   logic [CNT_W-1:0] stall_cnt_o;
   logic [CNT_W-1:0] flush_cnt_o;
   modport master (
      output dec_valid_i, dec_rs1_i, dec_rs2_i, dec_rs1_used_i, dec_rs2_used_i,
             dec_is_load_i, dec_wena_i, dec_waddr_i, ex_ready_i, flush_i,
      input  dec_ready_o, ex_valid_o, we_o, stall_cnt_o, flush_cnt_o
   );
   modport slave (
      input  dec_valid_i, dec_rs1_i, dec_rs2_i, dec_rs1_used_i, dec_rs2_used_i,
             dec_is_load_i, dec_wena_i, dec_waddr_i, ex_ready_i, flush_i,
      output dec_ready_o, ex_valid_o, we_o, stall_cnt_o, flush_cnt_o
   );
endinterface

// File: rtl/execute_hazard.sv
// execute_hazard: load-use hazard detect between the load in EX and the offered instruction's sources.
module execute_hazard (
   input  logic       ex_valid,
   input  logic       ld_pend,
   input  logic [4:0] ld_waddr,
   input  logic [4:0] rs1,
   input  logic [4:0] rs2,
   input  logic       rs1_used,
   input  logic       rs2_used,
   output logic       hazard
);
   assign hazard = ex_valid & ld_pend & (ld_waddr != 5'd0) &
                   ((rs1_used & (rs1 == ld_waddr)) | (rs2_used & (rs2 == ld_waddr)));
endmodule

// File: rtl/execute_ctrl.sv
// execute_ctrl: execute-stage valid/ready control with load-use stall and flush.
// Perf counters are built only when EXEC_CTRL_PERF_EN is defined; otherwise they read 0.
module execute_ctrl
   import execute_ctrl_pkg::*;
(
   input logic         clock,
   input logic         reset,
   execute_ctrl_if.slave bus
);
   state_t     state;
   logic       ld_pend;
   logic [4:0] ld_waddr;
   logic       hazard;
   logic       ex_valid;
   logic       dec_ready;
   logic       we;
   execute_hazard u_hazard (
      .ex_valid (ex_valid),
      .ld_pend  (ld_pend),
      .ld_waddr (ld_waddr),
      .rs1      (bus.dec_rs1_i),
      .rs2      (bus.dec_rs2_i),
      .rs1_used (bus.dec_rs1_used_i),
      .rs2_used (bus.dec_rs2_used_i),
      .hazard   (hazard)
   );
   assign ex_valid        = state != EMPTY;
   assign dec_ready       = !bus.flush_i & !hazard & (!ex_valid | bus.ex_ready_i);
   assign we              = bus.dec_valid_i & dec_ready;
   assign bus.ex_valid_o  = ex_valid;
   assign bus.dec_ready_o = dec_ready;
   assign bus.we_o        = we;
   // A live instruction that neither leaves nor is replaced parks in HOLD.
   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= EMPTY;
         ld_pend  <= 1'b0;
         ld_waddr <= 5'd0;
      end else begin
         state <= bus.flush_i               ? EMPTY :
                  we                        ? FULL  :
                  (ex_valid & bus.ex_ready_i) ? EMPTY :
                  ex_valid                  ? HOLD  : EMPTY;
         if (bus.flush_i) ld_pend <= 1'b0;
         else if (we) begin
            ld_pend  <= bus.dec_is_load_i & bus.dec_wena_i;
            ld_waddr <= bus.dec_waddr_i;
         end
      end
   end
`ifdef EXEC_CTRL_PERF_EN
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] flush_cnt;
   always_ff @(posedge clock) begin
      if (reset) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (bus.dec_valid_i & !dec_ready) stall_cnt <= sat_inc(stall_cnt);
         if (bus.flush_i & ex_valid) flush_cnt <= sat_inc(flush_cnt);
      end
   end
   assign bus.stall_cnt_o = stall_cnt;
   assign bus.flush_cnt_o = flush_cnt;
`else
   assign bus.stall_cnt_o = '0;
   assign bus.flush_cnt_o = '0;
`endif
endmodule

// File: tb/tb_execute_ctrl.sv
// tb_execute_ctrl: directed scenarios plus randomized run against a slot-level reference model.
module tb_execute_ctrl;
   import execute_ctrl_pkg::*;
`ifdef EXEC_CTRL_PERF_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif
   logic clock = 1'b0;
   logic reset = 1'b1;
   int   n_tests = 0;
   int   n_fail  = 0;
   execute_ctrl_if bus ();
   execute_ctrl dut (.clock(clock), .reset(reset), .bus(bus));
   always #5 clock = ~clock;

   task automatic idle();
      bus.dec_valid_i = 0; bus.dec_rs1_i = 0; bus.dec_rs2_i = 0;
      bus.dec_rs1_used_i = 0; bus.dec_rs2_used_i = 0; bus.dec_is_load_i = 0;
      bus.dec_wena_i = 0; bus.dec_waddr_i = 0; bus.ex_ready_i = 0; bus.flush_i = 0;
   endtask

   task automatic offer(input logic [4:0] rs1, input logic u1, input logic ld, input logic [4:0] rd);
      bus.dec_valid_i = 1; bus.dec_rs1_i = rs1; bus.dec_rs1_used_i = u1;
      bus.dec_rs2_i = 0; bus.dec_rs2_used_i = 0;
      bus.dec_is_load_i = ld; bus.dec_wena_i = 1; bus.dec_waddr_i = rd;
   endtask

   task automatic tick();
      @(posedge clock); #1;
   endtask

   task automatic do_reset();
      idle(); reset = 1; tick(); reset = 0;
   endtask

   task automatic test_reset();
      do_reset();
      bus.dec_valid_i = 1; #1;
      n_tests++; if (bus.ex_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_ex_valid got %b exp 0", bus.ex_valid_o); end
      n_tests++; if (bus.dec_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b exp 1", bus.dec_ready_o); end
      n_tests++; if (bus.we_o !== 1'b1) begin n_fail++; $display("FAIL reset_we got %b exp 1", bus.we_o); end
      n_tests++; if (bus.stall_cnt_o !== 32'd0 || bus.flush_cnt_o !== 32'd0) begin n_fail++; $display("FAIL reset_cnt got %0d/%0d exp 0/0", bus.stall_cnt_o, bus.flush_cnt_o); end
      n_tests++; if (dut.state !== EMPTY) begin n_fail++; $display("FAIL reset_state got %0d exp %0d", dut.state, EMPTY); end
   endtask

   task automatic test_stream();
      do_reset();
      offer(5'd1, 1, 0, 5'd2); bus.ex_ready_i = 1;
      for (int i = 0; i < 6; i++) begin
         #1;
         n_tests++; if (bus.we_o !== 1'b1) begin n_fail++; $display("FAIL stream_we c%0d got %b exp 1", i, bus.we_o); end
         n_tests++; if (bus.ex_valid_o !== (i > 0)) begin n_fail++; $display("FAIL stream_ex_valid c%0d got %b exp %b", i, bus.ex_valid_o, i > 0); end
         tick();
      end
      n_tests++; if (bus.stall_cnt_o !== 32'd0) begin n_fail++; $display("FAIL stream_stall got %0d exp 0", bus.stall_cnt_o); end
   endtask

   task automatic test_load_use();
      do_reset();
      bus.ex_ready_i = 1;
      offer(5'd0, 0, 1, 5'd5); #1;
      n_tests++; if (bus.we_o !== 1'b1) begin n_fail++; $display("FAIL lu_load_we got %b exp 1", bus.we_o); end
      tick();
      offer(5'd5, 1, 0, 5'd6); #1;
      n_tests++; if (bus.dec_ready_o !== 1'b0 || bus.we_o !== 1'b0) begin n_fail++; $display("FAIL lu_stall ready/we got %b/%b exp 0/0", bus.dec_ready_o, bus.we_o); end
      tick(); #1;
      n_tests++; if (bus.ex_valid_o !== 1'b0) begin n_fail++; $display("FAIL lu_bubble ex_valid got %b exp 0", bus.ex_valid_o); end
      n_tests++; if (bus.we_o !== 1'b1) begin n_fail++; $display("FAIL lu_accept we got %b exp 1", bus.we_o); end
      tick(); bus.dec_valid_i = 0; #1;
      n_tests++; if (bus.ex_valid_o !== 1'b1) begin n_fail++; $display("FAIL lu_dep_live got %b exp 1", bus.ex_valid_o); end
      n_tests++; if (bus.stall_cnt_o !== (PERF ? 32'd1 : 32'd0)) begin n_fail++; $display("FAIL lu_stall_cnt got %0d exp %0d", bus.stall_cnt_o, PERF ? 1 : 0); end
   endtask

   task automatic test_x0();
      do_reset();
      bus.ex_ready_i = 1;
      offer(5'd0, 0, 1, 5'd0); tick();
      offer(5'd0, 1, 0, 5'd3); #1;
      n_tests++; if (bus.we_o !== 1'b1) begin n_fail++; $display("FAIL x0_we got %b exp 1", bus.we_o); end
      tick();
      n_tests++; if (bus.stall_cnt_o !== 32'd0) begin n_fail++; $display("FAIL x0_stall got %0d exp 0", bus.stall_cnt_o); end
   endtask

   task automatic test_hold();
      do_reset();
      bus.ex_ready_i = 1;
      offer(5'd1, 0, 0, 5'd7); tick();
      bus.ex_ready_i = 0;
      for (int i = 0; i < 3; i++) begin
         #1;
         n_tests++; if (bus.we_o !== 1'b0 || bus.ex_valid_o !== 1'b1) begin n_fail++; $display("FAIL hold_c%0d we/ex_valid got %b/%b exp 0/1", i, bus.we_o, bus.ex_valid_o); end
         tick();
      end
      bus.dec_valid_i = 0; #1;
      n_tests++; if (dut.state !== HOLD) begin n_fail++; $display("FAIL hold_state got %0d exp %0d", dut.state, HOLD); end
      n_tests++; if (bus.stall_cnt_o !== (PERF ? 32'd3 : 32'd0)) begin n_fail++; $display("FAIL hold_stall_cnt got %0d exp %0d", bus.stall_cnt_o, PERF ? 3 : 0); end
   endtask

   task automatic test_flush();
      do_reset();
      bus.ex_ready_i = 1;
      offer(5'd0, 0, 1, 5'd5); tick();
      offer(5'd5, 1, 0, 5'd6); bus.flush_i = 1; #1;
      n_tests++; if (bus.we_o !== 1'b0) begin n_fail++; $display("FAIL flush_we got %b exp 0", bus.we_o); end
      tick(); bus.flush_i = 0; #1;
      n_tests++; if (bus.ex_valid_o !== 1'b0) begin n_fail++; $display("FAIL flush_ex_valid got %b exp 0", bus.ex_valid_o); end
      n_tests++; if (dut.ld_pend !== 1'b0) begin n_fail++; $display("FAIL flush_ld_pend got %b exp 0", dut.ld_pend); end
      n_tests++; if (bus.flush_cnt_o !== (PERF ? 32'd1 : 32'd0)) begin n_fail++; $display("FAIL flush_cnt got %0d exp %0d", bus.flush_cnt_o, PERF ? 1 : 0); end
      tick(); bus.dec_valid_i = 0; #1;
      n_tests++; if (bus.ex_valid_o !== 1'b1) begin n_fail++; $display("FAIL flush_refill got %b exp 1", bus.ex_valid_o); end
   endtask

   task automatic test_reset_flush();
      do_reset();
      bus.ex_ready_i = 1;
      offer(5'd1, 0, 0, 5'd2); tick();
      bus.ex_ready_i = 0; tick();
      bus.flush_i = 1; reset = 1; tick();
      reset = 0; bus.flush_i = 0; bus.dec_valid_i = 0; #1;
      n_tests++; if (dut.state !== EMPTY || bus.ex_valid_o !== 1'b0) begin n_fail++; $display("FAIL rstflush_state got %0d/%b exp %0d/0", dut.state, bus.ex_valid_o, EMPTY); end
      n_tests++; if (bus.stall_cnt_o !== 32'd0 || bus.flush_cnt_o !== 32'd0) begin n_fail++; $display("FAIL rstflush_cnt got %0d/%0d exp 0/0", bus.stall_cnt_o, bus.flush_cnt_o); end
   endtask

   typedef struct {bit live; bit is_ld; bit [4:0] rd;} slot_t;

   task automatic test_random();
      slot_t slot;
      bit    conflict, exp_ready, exp_we;
      int    m_stall, m_flush;
      do_reset();
      slot = '{0, 0, 0}; m_stall = 0; m_flush = 0;
      for (int i = 0; i < 400; i++) begin
         bus.dec_valid_i    = $urandom_range(3) != 0;
         bus.dec_rs1_i      = 5'($urandom_range(3));
         bus.dec_rs2_i      = 5'($urandom_range(3));
         bus.dec_rs1_used_i = 1'($urandom);
         bus.dec_rs2_used_i = 1'($urandom);
         bus.dec_is_load_i  = 1'($urandom);
         bus.dec_wena_i     = 1'($urandom);
         bus.dec_waddr_i    = 5'($urandom_range(3));
         bus.ex_ready_i     = $urandom_range(9) < 7;
         bus.flush_i        = $urandom_range(9) == 0;
         #1;
         conflict = slot.live && slot.is_ld && slot.rd != 0 &&
                    ((bus.dec_rs1_used_i && bus.dec_rs1_i == slot.rd) ||
                     (bus.dec_rs2_used_i && bus.dec_rs2_i == slot.rd));
         exp_ready = !bus.flush_i && !conflict && (!slot.live || bus.ex_ready_i);
         exp_we    = bus.dec_valid_i && exp_ready;
         n_tests++; if (bus.dec_ready_o !== exp_ready) begin n_fail++; $display("FAIL rnd_ready c%0d got %b exp %b", i, bus.dec_ready_o, exp_ready); end
         n_tests++; if (bus.we_o !== exp_we) begin n_fail++; $display("FAIL rnd_we c%0d got %b exp %b", i, bus.we_o, exp_we); end
         n_tests++; if (bus.ex_valid_o !== slot.live) begin n_fail++; $display("FAIL rnd_ex_valid c%0d got %b exp %b", i, bus.ex_valid_o, slot.live); end
         n_tests++; if (bus.stall_cnt_o !== (PERF ? 32'(m_stall) : 32'd0) || bus.flush_cnt_o !== (PERF ? 32'(m_flush) : 32'd0)) begin
            n_fail++; $display("FAIL rnd_cnt c%0d got %0d/%0d exp %0d/%0d", i, bus.stall_cnt_o, bus.flush_cnt_o, PERF ? m_stall : 0, PERF ? m_flush : 0);
         end
         if (bus.dec_valid_i && !exp_ready) m_stall++;
         if (bus.flush_i && slot.live) m_flush++;
         if (bus.flush_i) slot = '{0, 0, slot.rd};
         else if (exp_we) slot = '{1, bus.dec_is_load_i && bus.dec_wena_i, bus.dec_waddr_i};
         else if (bus.ex_ready_i) slot.live = 0;
         tick();
      end
   endtask

   initial begin
      idle();
      test_reset();
      test_stream();
      test_load_use();
      test_x0();
      test_hold();
      test_flush();
      test_reset_flush();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
